complex_add_fp64: RTL and testbench

// - Pipelined complex adder/subtractor on IEEE-754 binary64 operands: {re,im} of X +/- Y.
// - Sits beside complex_matrix_mul in the LU/triangular-inverse datapath.
// - Used for Schur-complement updates (C - A*B) with sub=1.
// - Two independent FP64 add lanes (real, imaginary) share one valid/ready pipeline.

---
 rtl/complex_add_fp64.sv | 260 ++++++++++++++++++++++++++
 tb/tb_complex_add_fp64.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_add_fp64.sv
// Pipelined complex adder/subtractor on IEEE-754 binary64 operands.
// Computes {Re, Im} of X + Y (sub=0) or X - Y (sub=1) with two independent
// FP64 lanes sharing one valid/ready pipeline (latency 2, throughput 1/cycle).
// Optional feature macro: CPLX_ADD_DENORM_EN
//   defined   - subnormal inputs at full precision, gradual underflow on output
//   undefined - subnormal inputs read as signed zero, tiny results flush to zero
// Note: rst_ni is an active-high asynchronous reset in this block.
module complex_add_fp64 #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned NUM_OP = 4
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NUM_OP-1:0][WIDTH-1:0]    operands_i,
  input  logic                            sub,
  input  logic                            in_valid_i,
  output logic                            in_ready_o,
  input  logic                            flush_i,
  output logic [1:0][WIDTH-1:0]           result_o,
  output logic                            out_valid_o,
  input  logic                            out_ready_i,
  output logic                            busy_o
);

  localparam logic [63:0] QNan = 64'h7FF8_0000_0000_0000;

  // Per-lane state carried from the align stage to the add/round stage.
  typedef struct packed {
    logic        spec;       // special result (NaN/Inf) overrides arithmetic
    logic [63:0] spec_val;
    logic        sign_l;     // sign of the larger-magnitude operand
    logic        zero_sign;  // sign of an exact-zero sum: only (-0)+(-0) is negative
    logic        eff_sub;    // operand signs differ after the sub adjustment
    logic [10:0] exp_l;      // biased exponent of the larger operand (>= 1)
    logic [55:0] mant_l;     // {hidden, frac, g, r, s}
    logic [55:0] mant_s;     // smaller mantissa, aligned, sticky folded into bit 0
  } s1_t;

  // Leading-zero count over 56 bits; returns 56 for an all-zero input.
  function automatic logic [5:0] lzc56(input logic [55:0] v);
    logic [5:0] n;
    logic       found;
    n     = 6'd56;
    found = 1'b0;
    for (int i = 55; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = 6'(55 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  // Stage 1: unpack, sign adjust, special detect, swap and align with sticky.
  function automatic s1_t stage1(input logic [63:0] x, input logic [63:0] y,
                                 input logic neg_y);
    logic        sx, sy, sl;
    logic [10:0] ex, ey, ex_eff, ey_eff, el, es, diff;
    logic [51:0] fx, fy;
    logic [52:0] mx, my, ml, ms;
    logic        x_nan, y_nan, x_inf, y_inf, swap, sticky;
    logic [55:0] ms_ext, ms_sh, lost_mask;
    s1_t         r;

    sx = x[63];
    sy = y[63] ^ neg_y;
    ex = x[62:52];
    ey = y[62:52];
    fx = x[51:0];
    fy = y[51:0];

    x_nan = (ex == 11'h7FF) && (fx != 52'd0);
    y_nan = (ey == 11'h7FF) && (fy != 52'd0);
    x_inf = (ex == 11'h7FF) && (fx == 52'd0);
    y_inf = (ey == 11'h7FF) && (fy == 52'd0);

`ifdef CPLX_ADD_DENORM_EN
    mx = {ex != 11'd0, fx};
    my = {ey != 11'd0, fy};
`else
    // Subnormals (and zeros) carry no magnitude; their sign is kept.
    mx = (ex != 11'd0) ? {1'b1, fx} : 53'd0;
    my = (ey != 11'd0) ? {1'b1, fy} : 53'd0;
`endif
    // Exponent field 0 scales like field 1 (subnormal encoding).
    ex_eff = (ex == 11'd0) ? 11'd1 : ex;
    ey_eff = (ey == 11'd0) ? 11'd1 : ey;

    swap = {ey_eff, my} > {ex_eff, mx};
    if (swap) begin
      el = ey_eff;
      ml = my;
      sl = sy;
      es = ex_eff;
      ms = mx;
    end else begin
      el = ex_eff;
      ml = mx;
      sl = sx;
      es = ey_eff;
      ms = my;
    end

    diff      = el - es;
    ms_ext    = {ms, 3'b000};
    lost_mask = '0;
    if (diff >= 11'd56) begin
      ms_sh  = '0;
      sticky = |ms_ext;
    end else begin
      lost_mask = ~({56{1'b1}} << diff[5:0]);
      ms_sh     = ms_ext >> diff[5:0];
      sticky    = |(ms_ext & lost_mask);
    end

    r.spec = x_nan | y_nan | x_inf | y_inf;
    if (x_nan || y_nan || (x_inf && y_inf && (sx != sy))) begin
      r.spec_val = QNan;
    end else if (x_inf) begin
      r.spec_val = {sx, 11'h7FF, 52'd0};
    end else if (y_inf) begin
      r.spec_val = {sy, 11'h7FF, 52'd0};
    end else begin
      r.spec_val = '0;
    end
    r.sign_l    = sl;
    r.zero_sign = sx & sy;
    r.eff_sub   = sx ^ sy;
    r.exp_l     = el;
    r.mant_l    = {ml, 3'b000};
    r.mant_s    = {ms_sh[55:1], ms_sh[0] | sticky};
    return r;
  endfunction

  // Stage 2: add/sub, normalise, round-to-nearest-even, pack.
  function automatic logic [63:0] stage2(input s1_t s);
    logic [56:0] sum;
    logic [55:0] m;
    logic [5:0]  lz, sh;
    logic [12:0] e, e_out;
    logic [53:0] rnd;
    logic [51:0] frac;
    logic        round_up;
    logic [63:0] res;
`ifdef CPLX_ADD_DENORM_EN
    logic [12:0] el_m1;
`endif

    if (s.eff_sub) begin
      sum = {1'b0, s.mant_l} - {1'b0, s.mant_s};
    end else begin
      sum = {1'b0, s.mant_l} + {1'b0, s.mant_s};
    end
    lz = lzc56(sum[55:0]);

    if (sum[56]) begin
      // Carry out: shift right one, keep the dropped bit as sticky.
      sh = 6'd0;
      m  = {sum[56:2], sum[1] | sum[0]};
      e  = {2'b00, s.exp_l} + 13'd1;
    end else begin
`ifdef CPLX_ADD_DENORM_EN
      // Stop normalising at exponent 1 so the result lands as a subnormal.
      el_m1 = {2'b00, s.exp_l} - 13'd1;
      if ({7'd0, lz} <= el_m1) begin
        sh = lz;
      end else begin
        sh = el_m1[5:0];
      end
`else
      sh = lz;
`endif
      m = sum[55:0] << sh;
      e = {2'b00, s.exp_l} - {7'd0, sh};
    end

    round_up = m[2] & (m[1] | m[0] | m[3]);
    rnd      = {1'b0, m[55:3]} + {53'd0, round_up};
    if (rnd[53]) begin
      // Rounding carried out of the mantissa: 1.0 at the next exponent.
      e_out = e + 13'd1;
      frac  = 52'd0;
    end else if (rnd[52]) begin
      e_out = e;
      frac  = rnd[51:0];
    end else begin
      e_out = 13'd0;
      frac  = rnd[51:0];
    end

    if (s.spec) begin
      res = s.spec_val;
    end else if (sum == 57'd0) begin
      res = {s.zero_sign, 63'd0};
`ifndef CPLX_ADD_DENORM_EN
    end else if (!sum[56] && ($signed(e) < 13'sd1)) begin
      res = {s.sign_l, 63'd0};
`endif
    end else if (e_out >= 13'd2047) begin
      res = {s.sign_l, 11'h7FF, 52'd0};
    end else begin
      res = {s.sign_l, e_out[10:0], frac};
    end
    return res;
  endfunction

  logic        stall, accept;
  logic        s1_valid_q, s2_valid_q;
  s1_t         s1_re_d, s1_im_d, s1_re_q, s1_im_q;
  logic [63:0] res_re_d, res_im_d;
  logic [1:0][63:0] result_q;

  assign stall       = s2_valid_q & ~out_ready_i;
  assign in_ready_o  = ~stall;
  assign accept      = in_valid_i & in_ready_o & ~flush_i;
  assign out_valid_o = s2_valid_q;
  assign result_o    = result_q;
  assign busy_o      = s1_valid_q | s2_valid_q;

  // Per-lane combinational datapath for both stages.
  always_comb begin
    s1_re_d  = stage1(operands_i[0], operands_i[2], sub);
    s1_im_d  = stage1(operands_i[1], operands_i[3], sub);
    res_re_d = stage2(s1_re_q);
    res_im_d = stage2(s1_im_q);
  end

  // Stage 1 register: captures aligned operands on accept, holds on stall.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_re_q    <= '0;
      s1_im_q    <= '0;
    end else if (flush_i) begin
      s1_valid_q <= 1'b0;
    end else if (!stall) begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_re_q <= s1_re_d;
        s1_im_q <= s1_im_d;
      end
    end
  end

  // Stage 2 register: packed results driving result_o, held on stall.
  always_ff @(posedge clk_i or posedge rst_ni) begin
    if (rst_ni) begin
      s2_valid_q <= 1'b0;
      result_q   <= '0;
    end else if (flush_i) begin
      s2_valid_q <= 1'b0;
    end else if (!stall) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        result_q <= {res_im_d, res_re_d};
      end
    end
  end

endmodule

// File: tb/tb_complex_add_fp64.sv
// Directed bench for complex_add_fp64: arithmetic vectors, stall, flush, reset.
module tb_complex_add_fp64;

  localparam logic [63:0] ONE      = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] TWO      = 64'h4000_0000_0000_0000;
  localparam logic [63:0] THREE    = 64'h4008_0000_0000_0000;
  localparam logic [63:0] FOUR     = 64'h4010_0000_0000_0000;
  localparam logic [63:0] FIVE     = 64'h4014_0000_0000_0000;
  localparam logic [63:0] SIX      = 64'h4018_0000_0000_0000;
  localparam logic [63:0] EIGHT    = 64'h4020_0000_0000_0000;
  localparam logic [63:0] HALF     = 64'h3FE0_0000_0000_0000;
  localparam logic [63:0] ONE_HALF = 64'h3FF8_0000_0000_0000;
  localparam logic [63:0] NEG_ONE  = 64'hBFF0_0000_0000_0000;
  localparam logic [63:0] QNAN     = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] PINF     = 64'h7FF0_0000_0000_0000;
  localparam logic [63:0] NINF     = 64'hFFF0_0000_0000_0000;
  localparam logic [63:0] PZERO    = 64'h0000_0000_0000_0000;
  localparam logic [63:0] NZERO    = 64'h8000_0000_0000_0000;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [3:0][63:0] operands_i;
  logic             sub;
  logic             in_valid_i;
  logic             in_ready_o;
  logic             flush_i;
  logic [1:0][63:0] result_o;
  logic             out_valid_o;
  logic             out_ready_i;
  logic             busy_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk_i = ~clk_i;

  complex_add_fp64 #(
    .WIDTH (64),
    .NUM_OP(4)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .operands_i (operands_i),
    .sub        (sub),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .flush_i    (flush_i),
    .result_o   (result_o),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .busy_o     (busy_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [63:0] xr, input logic [63:0] xi, input logic [63:0] yr,
                       input logic [63:0] yi, input logic s);
    operands_i = {yi, yr, xi, xr};
    sub        = s;
  endtask

  // One isolated transaction: checks latency and both lanes.
  task automatic run_one(input string tag, input logic [63:0] xr, input logic [63:0] xi,
                         input logic [63:0] yr, input logic [63:0] yi, input logic s,
                         input logic [63:0] er, input logic [63:0] ei);
    @(negedge clk_i);
    drive(xr, xi, yr, yi, s);
    in_valid_i  = 1'b1;
    out_ready_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #1;
    check_eq({tag, "_early"}, 64'(out_valid_o), 64'd0);
    @(negedge clk_i);
    #1;
    check_eq({tag, "_valid"}, 64'(out_valid_o), 64'd1);
    check_eq({tag, "_re"}, result_o[0], er);
    check_eq({tag, "_im"}, result_o[1], ei);
  endtask

  logic [63:0] st_x [4];
  logic [63:0] st_re[4];
  logic [63:0] st_im[4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    st_x  = '{ONE, TWO, THREE, FOUR};
    st_re = '{TWO, THREE, FOUR, FIVE};
    st_im = '{TWO, FOUR, SIX, EIGHT};

    rst_ni      = 1'b1;
    operands_i  = '0;
    sub         = 1'b0;
    in_valid_i  = 1'b0;
    flush_i     = 1'b0;
    out_ready_i = 1'b1;

    // Reset state
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    check_eq("rst_valid", 64'(out_valid_o), 64'd0);
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    check_eq("rst_res_re", result_o[0], 64'd0);
    check_eq("rst_res_im", result_o[1], 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check_eq("rst_ready", 64'(in_ready_o), 64'd1);

    // Arithmetic vectors
    run_one("sub_basic", ONE_HALF, TWO, HALF, NEG_ONE, 1'b1, ONE, THREE);
    run_one("cancel", 64'h400A_0000_0000_0000, PZERO, 64'hC00A_0000_0000_0000, PZERO, 1'b0,
            PZERO, PZERO);
    run_one("inf_inf", PINF, ONE, PINF, ONE, 1'b1, QNAN, PZERO);
    run_one("rnd_ovf", 64'h3FFF_FFFF_FFFF_FFFF, 64'h7FEF_FFFF_FFFF_FFFF,
            64'h3CA0_0000_0000_0000, 64'h7FEF_FFFF_FFFF_FFFF, 1'b0, TWO, PINF);
    run_one("nan_lane", 64'h7FF0_0000_0000_0001, ONE, ONE, TWO, 1'b0, QNAN, THREE);
    run_one("inf_nzero", NINF, NZERO, FIVE, NZERO, 1'b0, NINF, NZERO);
    run_one("normalise", ONE, ONE, 64'h3FE8_0000_0000_0000, 64'h3FF0_0000_0000_0001, 1'b1,
            64'h3FD0_0000_0000_0000, 64'hBCB0_0000_0000_0000);
`ifdef CPLX_ADD_DENORM_EN
    run_one("subnormal", 64'h1, 64'h0010_0000_0000_0001, 64'h1, 64'h8010_0000_0000_0000,
            1'b0, 64'h2, 64'h1);
`else
    run_one("subnormal", 64'h1, 64'h0010_0000_0000_0001, 64'h1, 64'h8010_0000_0000_0000,
            1'b0, PZERO, PZERO);
`endif

    // Stream of 4 with a 3-cycle downstream stall on the first result
    begin : stream
      int   idx;
      int   nout;
      int   stall_left;
      logic first_seen;
      idx        = 0;
      nout       = 0;
      stall_left = 0;
      first_seen = 1'b0;
      for (int c = 0; c < 40 && nout < 4; c++) begin
        @(negedge clk_i);
        #1;
        if (out_valid_o && !first_seen) begin
          first_seen = 1'b1;
          stall_left = 3;
        end
        out_ready_i = (stall_left == 0);
        #1;
        if (stall_left != 0) begin
          check_eq("stall_ready", 64'(in_ready_o), 64'd0);
          check_eq("stall_valid", 64'(out_valid_o), 64'd1);
          check_eq("stall_hold_re", result_o[0], st_re[0]);
          check_eq("stall_hold_im", result_o[1], st_im[0]);
          stall_left--;
        end
        if (out_valid_o && out_ready_i) begin
          check_eq("stream_re", result_o[0], st_re[nout]);
          check_eq("stream_im", result_o[1], st_im[nout]);
          nout++;
        end
        if (idx < 4 && in_ready_o) begin
          drive(st_x[idx], st_x[idx], ONE, st_x[idx], 1'b0);
          in_valid_i = 1'b1;
          idx++;
        end else begin
          in_valid_i = 1'b0;
        end
      end
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      check_eq("stream_count", 64'(nout), 64'd4);
    end

    // Flush one cycle after acceptance
    @(negedge clk_i);
    drive(ONE, ONE, ONE, ONE, 1'b0);
    in_valid_i = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    flush_i    = 1'b1;
    #1;
    check_eq("flush_busy_pre", 64'(busy_o), 64'd1);
    @(negedge clk_i);
    flush_i = 1'b0;
    #1;
    check_eq("flush_valid_1", 64'(out_valid_o), 64'd0);
    @(negedge clk_i);
    #1;
    check_eq("flush_valid_2", 64'(out_valid_o), 64'd0);
    check_eq("flush_busy_post", 64'(busy_o), 64'd0);
    @(negedge clk_i);
    #1;
    check_eq("flush_valid_3", 64'(out_valid_o), 64'd0);

    // Flush wins over a simultaneous input
    @(negedge clk_i);
    drive(ONE, ONE, ONE, ONE, 1'b0);
    in_valid_i = 1'b1;
    flush_i    = 1'b1;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
    #1;
    check_eq("flush_win_busy", 64'(busy_o), 64'd0);
    @(negedge clk_i);
    #1;
    check_eq("flush_win_valid", 64'(out_valid_o), 64'd0);

    // Reset with two transactions in flight
    @(negedge clk_i);
    drive(ONE, ONE, ONE, ONE, 1'b0);
    in_valid_i = 1'b1;
    @(negedge clk_i);
    drive(TWO, TWO, ONE, ONE, 1'b0);
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #1;
    check_eq("midrst_valid_pre", 64'(out_valid_o), 64'd1);
    rst_ni = 1'b1;
    #1;
    check_eq("midrst_valid", 64'(out_valid_o), 64'd0);
    check_eq("midrst_busy", 64'(busy_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b0;
    run_one("post_rst", TWO, TWO, TWO, TWO, 1'b0, FOUR, FOUR);

    @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
